// File: rtl/tow_pkg.sv
// Shared types and constants for the Tug of War round referee.
package tow_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned WIN_W = 2;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [WIN_W-1:0] WIN_NONE = 2'b00;
    localparam logic [WIN_W-1:0] WIN_L    = 2'b01;
    localparam logic [WIN_W-1:0] WIN_R    = 2'b10;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_digit.sv
// Combinational 4-bit to active-low seven-segment decoder; values above 9 blank.
module seg7_digit
    import tow_pkg::*;
(
    input  logic [3:0]       value,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (value)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/tow_referee.sv
// Tug of War round referee: detects round wins at the end lights, keeps scores,
// holds the playfield clear between rounds and drives the two score digits.
module tow_referee
    import tow_pkg::*;
#(
    parameter int unsigned MAX_SCORE   = 7,
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               L,
    input  logic                               R,
    input  logic                               end_l,
    input  logic                               end_r,
    output logic                               playfield_clr,
    output logic [WIN_W-1:0]                   winner,
    output logic [$clog2(MAX_SCORE + 1)-1:0]   score_l,
    output logic [$clog2(MAX_SCORE + 1)-1:0]   score_r,
    output logic [SEG_W-1:0]                   hex_l,
    output logic [SEG_W-1:0]                   hex_r
);

    localparam int unsigned SW = $clog2(MAX_SCORE + 1);
    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [SW-1:0]    score_l_next;
    logic [SW-1:0]    score_r_next;
    logic [WIN_W-1:0] winner_next;
    logic             win_l_c;
    logic             win_r_c;

    // Simultaneous presses cancel; each side is qualified by its own end light
    assign win_l_c = end_l & L & ~R;
    assign win_r_c = end_r & R & ~L;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        score_l_next = score_l;
        score_r_next = score_r;
        winner_next  = winner;
        case (state)
            PLAY: begin
                if (win_l_c) begin
                    score_l_next = score_l + SW'(1);
                    winner_next  = WIN_L;
                    cnt_next     = CW'(HOLD_CYCLES - 1);
                    state_next   = (score_l_next == SW'(MAX_SCORE)) ? OVER : HOLD;
                end else if (win_r_c) begin
                    score_r_next = score_r + SW'(1);
                    winner_next  = WIN_R;
                    cnt_next     = CW'(HOLD_CYCLES - 1);
                    state_next   = (score_r_next == SW'(MAX_SCORE)) ? OVER : HOLD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_next = PLAY;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            OVER: begin
                state_next = OVER;
            end
            default: begin
                state_next = PLAY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= PLAY;
            cnt           <= '0;
            score_l       <= '0;
            score_r       <= '0;
            winner        <= WIN_NONE;
            playfield_clr <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            score_l       <= score_l_next;
            score_r       <= score_r_next;
            winner        <= winner_next;
            playfield_clr <= (state_next != PLAY);
        end
    end

    seg7_digit u_digit_l (
        .value (4'(score_l)),
        .seg_c (hex_l)
    );

    seg7_digit u_digit_r (
        .value (4'(score_r)),
        .seg_c (hex_r)
    );

endmodule

// File: tb/tb_tow_referee.sv
// Randomised scoreboard bench for tow_referee against a round-level game model.
module tb_tow_referee;

    localparam int unsigned MS = 3;
    localparam int unsigned HC = 4;
    localparam int unsigned SW = $clog2(MS + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          L = 1'b0;
    logic          R = 1'b0;
    logic          end_l = 1'b0;
    logic          end_r = 1'b0;
    logic          playfield_clr;
    logic [1:0]    winner;
    logic [SW-1:0] score_l;
    logic [SW-1:0] score_r;
    logic [6:0]    hex_l;
    logic [6:0]    hex_r;

    tow_referee #(.MAX_SCORE(MS), .HOLD_CYCLES(HC)) dut (
        .clk           (clk),
        .reset         (reset),
        .L             (L),
        .R             (R),
        .end_l         (end_l),
        .end_r         (end_r),
        .playfield_clr (playfield_clr),
        .winner        (winner),
        .score_l       (score_l),
        .score_r       (score_r),
        .hex_l         (hex_l),
        .hex_r         (hex_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        int clr;
        int win;
        int sl;
        int sr;
        int hl;
        int hr;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    // Game model: scores, last winner, remaining cleared cycles, match-over flag
    int m_sl = 0;
    int m_sr = 0;
    int m_win = 0;
    int m_left = 0;
    bit m_over = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit l, input bit r, input bit el, input bit er);
        exp_t e;
        @(negedge clk);
        reset = rst;
        L     = l;
        R     = r;
        end_l = el;
        end_r = er;
        if (!rst) begin
            m_sl = 0; m_sr = 0; m_win = 0; m_left = 0; m_over = 1'b0;
        end else if (m_over) begin
            // match finished: nothing changes until reset
        end else if (m_left > 0) begin
            m_left--;
        end else if (el && l && !r) begin
            m_sl++; m_win = 1; m_left = HC;
            if (m_sl == MS) m_over = 1'b1;
        end else if (er && r && !l) begin
            m_sr++; m_win = 2; m_left = HC;
            if (m_sr == MS) m_over = 1'b1;
        end
        e.clr = (m_over || m_left > 0) ? 1 : 0;
        e.win = m_win;
        e.sl  = m_sl;
        e.sr  = m_sr;
        e.hl  = int'(seg_tab[m_sl]);
        e.hr  = int'(seg_tab[m_sr]);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    // Monitor: outputs settle after each edge; compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("playfield_clr", int'(playfield_clr), e.clr);
                chk("winner",        int'(winner),        e.win);
                chk("score_l",       int'(score_l),       e.sl);
                chk("score_r",       int'(score_r),       e.sr);
                chk("hex_l",         int'(hex_l),         e.hl);
                chk("hex_r",         int'(hex_r),         e.hr);
            end
        end
    end

    initial begin
        int budget;
        // reset, then idle
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        idle(2);
        // left win and full hold
        step(1, 1, 0, 1, 0);
        idle(6);
        // second left win, right press during hold ignored
        step(1, 1, 0, 1, 0);
        step(1, 0, 1, 0, 1);
        idle(5);
        // simultaneous presses, and presses at the wrong end
        step(1, 1, 1, 0, 1);
        step(1, 1, 1, 1, 0);
        step(1, 1, 0, 0, 1);
        step(1, 0, 1, 1, 0);
        idle(1);
        // three right wins end the match; later presses ignored
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 1, 0, 1);
            idle(5);
        end
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 1, 0, 1);
            idle(1);
        end
        // reset during second hold cycle, immediate press scores
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        idle(1);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        idle(6);
        // randomised play
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0);
        end
        // drain with bounded wait
        budget = 10;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tow_referee.md
# tow_referee

Round referee for the Tug of War game, sitting directly downstream of the playfield light chain. It watches the two end lights and the conditioned player press pulses, declares a round winner when a player pulls the light off their end, keeps per-player scores, and drives two seven-segment digits. It also emits a playfield-clear strobe that restarts the light chain after each round.

## Interface
- `MAX_SCORE`, default 7: score that ends the match; legal range 1..9 (single decimal digit).
- `HOLD_CYCLES`, default 50_000_000: clk cycles the win is displayed before the next round; must be ≥ 1.
- `clk`  in  1  system clock (CLOCK_50 domain).
- `reset`  in  1  synchronous, active-low reset.
- `L`  in  1  left-player press, one-cycle pulse, already synchronised.
- `R`  in  1  right-player press, one-cycle pulse, already synchronised.
- `end_l`  in  1  leftmost playfield light.
- `end_r`  in  1  rightmost playfield light.
- `playfield_clr`  out  1  high while the playfield must be held at its initial pattern; top level ORs it into the light-chain reset.
- `winner`  out  2  00 none, 01 left won last round, 10 right won last round; 11 never driven.
- `score_l`  out  `$clog2(MAX_SCORE+1)`  left score.
- `score_r`  out  `$clog2(MAX_SCORE+1)`  right score.
- `hex_l`  out  7  active-low segments {g,f,e,d,c,b,a} showing `score_l`.
- `hex_r`  out  7  active-low segments showing `score_r`.

## Operation
- States: PLAY, HOLD, OVER.
- PLAY: left win when `end_l & L & ~R`; right win when `end_r & R & ~L`. `L & R` in the same cycle is ignored. Both ends lit cannot occur in normal play; if it does, the enabled condition is evaluated for each side independently, and `L & R` still yields no win.
- On a win: the winner's score increments by 1, `winner` is set, and the hold counter loads `HOLD_CYCLES-1`. The next state is OVER if the new score equals `MAX_SCORE`; otherwise it is HOLD.
- HOLD: the counter decrements each cycle and inputs are ignored. At counter 0 the block returns to PLAY. `winner` keeps its value until the next win or reset.
- OVER: terminal state. Inputs are ignored, scores are frozen, and `playfield_clr` stays high until `reset` is low.
- Scores never exceed `MAX_SCORE`; there is no wrap.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Values above 9 show blank (1111111).
- Reset (`reset`==0 at a clk edge): state PLAY, scores 0, `winner`=00, counter 0, `playfield_clr`=0, both hex outputs show 1000000. Reset asserted mid-HOLD or in OVER takes effect on that edge and aborts the hold.

## Timing
- All outputs are registered or decoded from registers; there is no combinational input-to-output path.
- Win condition sampled at edge N: at N+1 the score is updated, `winner` is valid, and `playfield_clr`=1.
- `playfield_clr` is high for exactly `HOLD_CYCLES` cycles (N+1 .. N+`HOLD_CYCLES`). PLAY resumes and `playfield_clr` falls at N+`HOLD_CYCLES`+1.
- A press is first evaluated in the cycle PLAY is entered.
- Hex outputs follow the score in the same cycle.
- In OVER, `playfield_clr` is constant 1.

## Structure
- Package `tow_pkg`:
  - state enum {PLAY, HOLD, OVER};
  - winner codes WIN_NONE/WIN_L/WIN_R;
  - segment constants SEG_0..SEG_9 and SEG_BLANK.
- Sub-module `seg7_digit`: purely combinational 4-bit→7-segment decoder, instantiated twice.
- Referee FSM, hold counter and score registers live in `tow_referee`. Counter width is `$clog2(HOLD_CYCLES)`, minimum 1.

## Test plan
All scenarios use `MAX_SCORE`=3, `HOLD_CYCLES`=4.
- Reset low for 2 cycles, then high → scores 0/0, `winner`=00, `playfield_clr`=0, `hex_l`=`hex_r`=1000000.
- `end_l`=1 with one-cycle `L` pulse → next cycle: `score_l`=1, `winner`=01, `hex_l`=1111001, `playfield_clr`=1 for exactly 4 cycles, then 0.
- During HOLD, pulse `R` with `end_r`=1 → no score change. Also `end_r`=1 with `L` and `R` both pulsed in PLAY → no win.
- Left-player press with `end_r` lit, and right-player press with `end_l` lit → no win.
- Three right wins → `score_r`=3, state OVER, `playfield_clr` stuck at 1. Further `R` pulses leave `score_r`=3 and `hex_r`=0110000.
- `reset` low during the second HOLD cycle → next edge: scores 0, `playfield_clr`=0, PLAY; an immediate valid left press is scored.
